noc_out_arbiter: RTL

Per-output-port packet arbiter for the NoC router. It collects the route requests that the five input-port LBDR units raise towards one output port (N, E, W, S, L) and grants that port to one requester at a time in round-robin order. The grant is held for the whole packet (wormhole locking) and released on the tail flit. It drives the crossbar select, the input-FIFO read enables and the output write strobe. The router instantiates one per output port.

---
 rtl/noc_out_arbiter_pkg.sv | 34 +++
 rtl/noc_out_arbiter_rr_pick.sv | 41 ++++
 rtl/noc_out_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/noc_out_arbiter_pkg.sv
// noc_out_arbiter_pkg
// Shared constants and types for the per-output-port packet arbiter.
// Flit type codes and the router port indices are shared with the
// LBDR units and the crossbar so that every block agrees on bit order.
//   HEADER/PAYLOAD/TAIL : 3-bit flit_id codes carried with each flit
//   N/E/W/S/L           : requester index of each input port
//   arb_state_t         : arbiter FSM state encoding
//   wd_cnt_width()      : width of the optional watchdog counter

package noc_out_arbiter_pkg;

  localparam logic [2:0] HEADER  = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL    = 3'b100;

  localparam int N = 0;
  localparam int E = 1;
  localparam int W = 2;
  localparam int S = 3;
  localparam int L = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // The watchdog counter must hold TIMEOUT and is never narrower than 8 bits.
  function automatic int wd_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/noc_out_arbiter_rr_pick.sv
// rr_pick
// Combinational circular priority search. Starting one position after
// `ptr` (the last-served index) and wrapping modulo NPORTS, it selects the
// first set bit of `req`. Kept standalone so the input-side VC allocator
// can reuse it.
// Ports:
//   req       in  NPORTS  request vector
//   ptr       in  3       last-served index
//   grant_oh  out NPORTS  one-hot winner (zero when no request)
//   grant_idx out 3       binary index of the winner
//   valid     out 1       at least one request present

module rr_pick #(
  parameter int NPORTS = 5
) (
  input  logic [NPORTS-1:0] req,
  input  logic [2:0]        ptr,
  output logic [NPORTS-1:0] grant_oh,
  output logic [2:0]        grant_idx,
  output logic              valid
);

  // Walk the candidates ptr+1 .. ptr+NPORTS; the first hit wins and later
  // hits are masked by `valid`, so the last-served input has lowest priority.
  always_comb begin
    int cand;
    grant_oh  = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NPORTS; k++) begin
      cand = (int'(ptr) + k) % NPORTS;
      if (!valid && req[cand]) begin
        valid          = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = 3'(cand);
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// noc_out_arbiter
// Per-output-port wormhole arbiter. Grants the output to one requesting
// input at a time in round-robin order, holds the grant for the whole
// packet and releases it when the tail flit actually transfers.
// Optional watchdog: define NOC_ARB_WATCHDOG_EN to compile in a stall
// counter that force-releases a lock after TIMEOUT idle LOCKED cycles.
// Ports:
//   clk          in  1       clock
//   rst          in  1       asynchronous active-high reset
//   req          in  NPORTS  LBDR route requests (0=N,1=E,2=W,3=S,4=L)
//   empty        in  NPORTS  input FIFO empty flags
//   out_full     in  1       downstream FIFO full (back-pressure)
//   flit_id_sel  in  3       flit_id at the head of the selected FIFO
//   grant        out NPORTS  registered one-hot grant
//   sel          out 3       registered crossbar select
//   rd_en        out NPORTS  read enable to the granted FIFO
//   wr_en        out 1       output write strobe, rd_en delayed one cycle
//   busy         out 1       FSM is LOCKED
//   timeout_err  out 1       watchdog release pulse (NOC_ARB_WATCHDOG_EN only)

module noc_out_arbiter
  import noc_out_arbiter_pkg::*;
#(
  parameter int NPORTS  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req,
  input  logic [NPORTS-1:0] empty,
  input  logic              out_full,
  input  logic [2:0]        flit_id_sel,
  output logic [NPORTS-1:0] grant,
  output logic [2:0]        sel,
  output logic [NPORTS-1:0] rd_en,
  output logic              wr_en,
  output logic              busy
`ifdef NOC_ARB_WATCHDOG_EN
  ,
  output logic              timeout_err
`endif
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [2:0]        ptr;
  logic [NPORTS-1:0] pick_oh;
  logic [2:0]        pick_idx;
  logic              pick_valid;
  logic              xfer;
  logic              tail_xfer;
  logic              release_lock;

  rr_pick #(
    .NPORTS(NPORTS)
  ) u_pick (
    .req      (req),
    .ptr      (ptr),
    .grant_oh (pick_oh),
    .grant_idx(pick_idx),
    .valid    (pick_valid)
  );

  // A transfer is any cycle the granted FIFO is read; only a transferred
  // tail ends the packet, a stalled tail keeps the lock.
  assign xfer      = |rd_en;
  assign tail_xfer = xfer && (flit_id_sel == TAIL);

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int WD_W = wd_cnt_width(TIMEOUT);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;

  assign wd_fire      = (state == LOCKED) && !xfer && (wd_cnt >= WD_W'(TIMEOUT));
  assign release_lock = tail_xfer || wd_fire;

  // Counter is held at zero outside LOCKED, so it starts from zero on
  // every new lock; any transfer restarts the stall count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_fire;
      if (state != LOCKED || xfer || wd_fire) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  assign release_lock = tail_xfer;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: any request locks, only a release returns to IDLE.
  // The IDLE cycle after a release is the mandatory inter-packet bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid)   state_nxt = LOCKED;
      LOCKED:  if (release_lock) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, select and pointer. sel is loaded only on IDLE->LOCKED so the
  // crossbar select never moves inside a packet; ptr records who was just
  // served so that input gets lowest priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
      sel   <= '0;
      ptr   <= 3'(NPORTS - 1);
    end else if (state == IDLE) begin
      if (pick_valid) begin
        grant <= pick_oh;
        sel   <= pick_idx;
      end
    end else if (release_lock) begin
      grant <= '0;
      ptr   <= sel;
    end
  end

  // FIFO data appears at the crossbar one cycle after the read, so the
  // output strobe is the read strobe delayed by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en <= 1'b0;
    end else begin
      wr_en <= xfer;
    end
  end

  // Outputs. grant is one-hot, so masking with ~empty leaves at most the
  // selected input's read enable.
  always_comb begin
    busy  = (state == LOCKED);
    rd_en = '0;
    if (state == LOCKED && !out_full) begin
      rd_en = grant & ~empty;
    end
  end

endmodule
